// File: rtl/simple_fifo_adapter.sv
// simple_fifo_adapter: narrow-to-wide packing FIFO.
// Beats pack LSB-first into wide words stored in a DEPTH-entry ring.
module simple_fifo_adapter #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 128,
  parameter int ADDR_WIDTH     = 4,
  parameter int FULL_SLACK     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_ena,
  input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
  input  logic                      wr_last,
  output logic                      wr_full,
  input  logic                      rd_ena,
  output logic [DATA_OUT_WIDTH-1:0] rd_dat,
  output logic                      rd_empty,
  output logic [ADDR_WIDTH:0]       rd_dat_cnt
);

  localparam int RATIO = DATA_OUT_WIDTH / DATA_IN_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_TH =
    (ADDR_WIDTH+1)'(DEPTH - FULL_SLACK);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(RATIO - 1);

  logic [DATA_OUT_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]       count;
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic [IDX_W-1:0]          idx;
  logic [DATA_OUT_WIDTH-1:0] pack;
  logic [DATA_OUT_WIDTH-1:0] word;

  logic beat_ok;
  logic commit;
  logic rd_ok;

  // Hard-full gate uses only the registered count, so reads
  // in the same edge never open a slot for a write.
  assign beat_ok = wr_ena && (count != DEPTH_C);
  assign commit  = beat_ok && (wr_last || (idx == LAST_IDX));
  assign rd_ok   = rd_ena && (count != '0);

  assign rd_empty   = (count == '0);
  assign rd_dat_cnt = count;
  assign wr_full    = (count >= FULL_TH);

  always_comb begin
    word = pack;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) begin
        word[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = wr_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      pack   <= '0;
      rd_dat <= '0;
    end else begin
      if (beat_ok) begin
        if (commit) begin
          idx    <= '0;
          pack   <= '0;
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          idx  <= idx + 1'b1;
          pack <= word;
        end
      end
      if (rd_ok) begin
        rd_dat <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({commit, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_ptr] <= word;
    end
  end

endmodule

// File: tb/tb_simple_fifo_adapter.sv
// tb_simple_fifo_adapter: directed checks for the packing FIFO.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_simple_fifo_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_ena;
  logic [15:0]  wr_dat;
  logic         wr_last;
  logic         wr_full;
  logic         rd_ena;
  logic [127:0] rd_dat;
  logic         rd_empty;
  logic [4:0]   rd_dat_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  simple_fifo_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .wr_ena     (wr_ena),
    .wr_dat     (wr_dat),
    .wr_last    (wr_last),
    .wr_full    (wr_full),
    .rd_ena     (rd_ena),
    .rd_dat     (rd_dat),
    .rd_empty   (rd_empty),
    .rd_dat_cnt (rd_dat_cnt)
  );

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    wr_ena  = 1'b1;
    wr_dat  = d;
    wr_last = last;
    tick();
    wr_ena  = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [127:0] exp);
    rd_ena = 1'b1;
    tick();
    rd_ena = 1'b0;
    check(tag, rd_dat, exp);
  endtask

  function automatic logic [127:0] lanes(input int base);
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(base + j);
    return w;
  endfunction

  localparam logic [127:0] NINES =
    128'h0009000900090009_0009000900090009;

  initial begin
    logic [15:0]  v [16];
    logic [127:0] e;
    int           mcnt;
    int           mbeat;
    bit           mcom;
    bit           mrd;

    rst = 1'b0; wr_ena = 1'b0; wr_dat = '0;
    wr_last = 1'b0; rd_ena = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst_empty", 128'(rd_empty), 128'd1);
    check("rst_cnt", 128'(rd_dat_cnt), 128'd0);
    check("rst_dat", rd_dat, 128'd0);
    check("rst_full", 128'(wr_full), 128'd0);

    // Fill and drain
    for (int i = 0; i < 128; i++) begin
      push(16'(i), 1'b0);
      if (i == 7) check("fill_cnt1", 128'(rd_dat_cnt), 128'd1);
      if (i == 111) check("full_at14", 128'(wr_full), 128'd0);
      if (i == 119) check("full_at15", 128'(wr_full), 128'd1);
    end
    repeat (100) tick();
    check("fill_cnt", 128'(rd_dat_cnt), 128'd16);
    check("fill_full", 128'(wr_full), 128'd1);
    check("fill_empty", 128'(rd_empty), 128'd0);
    pop("pop0_lit", 128'h0007000600050004_0003000200010000);
    for (int k = 1; k < 15; k++) pop("fill_pop", lanes(8*k));
    pop("pop15_lit", 128'h007F007E007D007C_007B007A00790078);
    check("drain_empty", 128'(rd_empty), 128'd1);
    check("drain_cnt", 128'(rd_dat_cnt), 128'd0);

    // Random packing
    for (int i = 0; i < 16; i++) begin
      v[i] = 16'($urandom_range(0, 255));
      push(v[i], 1'b0);
    end
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 8; j++) e[j*16 +: 16] = v[8*w + j];
      pop("rand_pop", e);
    end

    // Partial flush
    push(16'hAAAA, 1'b0);
    push(16'hBBBB, 1'b0);
    check("part_cnt0", 128'(rd_dat_cnt), 128'd0);
    check("part_empty0", 128'(rd_empty), 128'd1);
    push(16'hCCCC, 1'b1);
    check("part_cnt1", 128'(rd_dat_cnt), 128'd1);
    pop("part_pop", 128'h0000CCCCBBBBAAAA);

    // Overflow drop
    for (int i = 0; i < 136; i++) push(16'(i), 1'b0);
    check("ovf_cnt", 128'(rd_dat_cnt), 128'd16);
    for (int k = 0; k < 16; k++) pop("ovf_pop", lanes(8*k));
    check("ovf_empty", 128'(rd_empty), 128'd1);
    rd_ena = 1'b1;
    tick();
    rd_ena = 1'b0;
    check("empty_hold", rd_dat, lanes(120));
    check("empty_cnt", 128'(rd_dat_cnt), 128'd0);

    // Concurrent streaming
    wr_ena = 1'b1;
    wr_dat = 16'h0009;
    repeat (32) tick();
    check("strm_cnt4", 128'(rd_dat_cnt), 128'd4);
    mcnt  = 4;
    mbeat = 32;
    for (int t = 0; t < 33; t++) begin
      wr_ena = (t < 32);
      rd_ena = 1'b1;
      mcom = wr_ena && (mbeat % 8 == 7);
      mrd  = (mcnt > 0);
      if (wr_ena) mbeat++;
      tick();
      mcnt = mcnt + int'(mcom) - int'(mrd);
      check("strm_dat", rd_dat, NINES);
      check("strm_cnt", 128'(rd_dat_cnt), 128'(mcnt));
    end
    wr_ena = 1'b0;
    rd_ena = 1'b0;
    check("strm_empty", 128'(rd_empty), 128'd1);

    // Reset mid-operation
    for (int i = 0; i < 29; i++) push(16'(i + 16'h0200), 1'b0);
    check("mid_cnt3", 128'(rd_dat_cnt), 128'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_empty", 128'(rd_empty), 128'd1);
    check("mid_cnt", 128'(rd_dat_cnt), 128'd0);
    check("mid_dat", rd_dat, 128'd0);
    for (int i = 0; i < 8; i++) push(16'(i + 16'h0100), 1'b0);
    check("mid_cnt1", 128'(rd_dat_cnt), 128'd1);
    pop("mid_pop", lanes(16'h0100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
